bsg_alu_operand_sequencer: RTL and testbench

//  Upstream feeder and result collector for the combinational bsg_alu.

---
 rtl/bsg_alu_operand_sequencer_pkg.sv | 31 +++
 rtl/bsg_alu_operand_sequencer_if.sv | 44 ++++
 rtl/bsg_alu_operand_sequencer_result_slot.sv | 39 +++
 rtl/bsg_alu_operand_sequencer.sv | 157 +++++++++++++++
 tb/tb_bsg_alu_operand_sequencer.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bsg_alu_operand_sequencer_pkg.sv
// Shared types for the ALU operand sequencer: control code type, sequencer
// states and a width-parameterised record layout.
package bsg_alu_operand_sequencer_pkg;

    // Width of the bsg_alu control field and the number of codes it can encode.
    localparam int bsg_alu_ctrl_width_gp = 2;
    localparam int bsg_alu_num_ctrl_gp   = 1 << bsg_alu_ctrl_width_gp;

    typedef logic [bsg_alu_ctrl_width_gp-1:0] bsg_alu_ctrl_t;

    // Sequencer states: waiting for an operand pair, or walking the enabled codes.
    typedef enum logic {
        e_idle,
        e_sweep
    } bsg_alu_seq_state_e;

endpackage

`ifndef BSG_ALU_RECORD_S
`define BSG_ALU_RECORD_S
// Result record as emitted to the consumer: the code and operands that were
// applied to bsg_alu, the captured result, and a flag marking the final code.
`define BSG_ALU_RECORD_STRUCT(w) \
    struct packed { \
        bsg_alu_ctrl_t  ctrl; \
        logic [w-1:0]   a; \
        logic [w-1:0]   b; \
        logic [w-1:0]   res; \
        logic           last; \
    }
`endif

// File: rtl/bsg_alu_operand_sequencer_if.sv
// Bundle of every handshake and datapath signal between the sequencer, its
// operand producer, the attached bsg_alu and the record consumer.
// The slave modport is the sequencer's view; master is the environment's view.
interface bsg_alu_operand_sequencer_if
    import bsg_alu_operand_sequencer_pkg::*;
    #(parameter int width_p = 4);

    // Operand pair input channel (valid/ready).
    logic                 v_i;
    logic [width_p-1:0]   a_i;
    logic [width_p-1:0]   b_i;
    logic                 ready_o;

    // Drive to / result from the combinational bsg_alu.
    bsg_alu_ctrl_t        alu_control_o;
    logic [width_p-1:0]   alu_a_o;
    logic [width_p-1:0]   alu_b_o;
    logic [width_p-1:0]   alu_res_i;

    // Result record output channel (valid/yumi).
    logic                 v_o;
    bsg_alu_ctrl_t        control_o;
    logic [width_p-1:0]   a_o;
    logic [width_p-1:0]   b_o;
    logic [width_p-1:0]   res_o;
    logic                 last_o;
    logic                 yumi_i;

    // Status.
    logic                 busy_o;

    modport slave (
        input  v_i, a_i, b_i, alu_res_i, yumi_i,
        output ready_o, alu_control_o, alu_a_o, alu_b_o,
               v_o, control_o, a_o, b_o, res_o, last_o, busy_o
    );

    modport master (
        output v_i, a_i, b_i, alu_res_i, yumi_i,
        input  ready_o, alu_control_o, alu_a_o, alu_b_o,
               v_o, control_o, a_o, b_o, res_o, last_o, busy_o
    );

endinterface

// File: rtl/bsg_alu_operand_sequencer_result_slot.sv
// One-entry valid/yumi output register. An enqueue always wins over a
// dequeue in the same cycle, so a consumer that takes the held record while
// a new one arrives sees back-to-back records with no bubble.
module bsg_alu_operand_sequencer_result_slot #(
    parameter int width_p = 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               enq_i,
    input  logic [width_p-1:0] data_i,
    input  logic               yumi_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o
);

    logic               v_r;
    logic [width_p-1:0] data_r;

    // Slot occupancy and payload: load on enqueue, empty on a bare dequeue.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (reset_i) begin
            v_r    <= 1'b0;
            // NOTE: the payload is a single register, not a memory array, so it is
            // cleared on reset to give a defined record value after reset.
            data_r <= '0;
        end else if (enq_i) begin
            v_r    <= 1'b1;
            data_r <= data_i;
        end else if (yumi_i) begin
            v_r    <= 1'b0;
        end
    end

    assign v_o    = v_r;
    assign data_o = data_r;

endmodule

// File: rtl/bsg_alu_operand_sequencer.sv
// Upstream feeder and result collector for a combinational bsg_alu.
// Each accepted operand pair is swept through every control code enabled in
// op_mask_p, in ascending order; each ALU result is captured into a one-entry
// slot and offered as a {control, a, b, res, last} record over valid/yumi.
// A stalled consumer freezes the sweep, so the ALU inputs hold steady.
module bsg_alu_operand_sequencer
    import bsg_alu_operand_sequencer_pkg::*;
#(
    // Operand/result width; must match the interface instance and the bsg_alu.
    parameter int                             width_p   = 4,
    // Bit k set means control code k is issued for every pair.
    parameter logic [bsg_alu_num_ctrl_gp-1:0] op_mask_p = 4'b1111
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    bsg_alu_operand_sequencer_if.slave         io
);

    // An empty mask would leave the sequencer nothing to issue.
    if (op_mask_p == '0) begin : g_bad_mask
        $error("bsg_alu_operand_sequencer: op_mask_p must enable at least one code");
    end

    // Lowest enabled code: where every sweep starts.
    function automatic bsg_alu_ctrl_t first_code(input logic [bsg_alu_num_ctrl_gp-1:0] mask);
        first_code = '0;
        for (int k = bsg_alu_num_ctrl_gp - 1; k >= 0; k--) begin
            if (mask[k]) first_code = bsg_alu_ctrl_t'(k);
        end
    endfunction

    // Highest enabled code: the record carrying it is flagged last.
    function automatic bsg_alu_ctrl_t last_code(input logic [bsg_alu_num_ctrl_gp-1:0] mask);
        last_code = '0;
        for (int k = 0; k < bsg_alu_num_ctrl_gp; k++) begin
            if (mask[k]) last_code = bsg_alu_ctrl_t'(k);
        end
    endfunction

    // Next enabled code above cur; wraps to the first code past the top so the
    // op register always holds a legal code.
    function automatic bsg_alu_ctrl_t next_code(input logic [bsg_alu_num_ctrl_gp-1:0] mask,
                                                input bsg_alu_ctrl_t                  cur);
        logic found;
        next_code = first_code(mask);
        found     = 1'b0;
        for (int k = 0; k < bsg_alu_num_ctrl_gp; k++) begin
            if (!found && (k > int'(cur)) && mask[k]) begin
                next_code = bsg_alu_ctrl_t'(k);
                found     = 1'b1;
            end
        end
    endfunction

    localparam bsg_alu_ctrl_t first_code_lp = first_code(op_mask_p);
    localparam bsg_alu_ctrl_t last_code_lp  = last_code(op_mask_p);

    typedef `BSG_ALU_RECORD_STRUCT(width_p) record_t;

    bsg_alu_seq_state_e   state_r, state_n;
    bsg_alu_ctrl_t        op_r, op_n;
    logic [width_p-1:0]   a_r, a_n;
    logic [width_p-1:0]   b_r, b_n;

    logic                 capture;
    logic                 slot_v;
    record_t              enq_rec;
    record_t              slot_rec;

    // A result is taken whenever sweeping and the slot is free or being emptied.
    assign capture = (state_r == e_sweep) & (~slot_v | io.yumi_i);

    // Sequencer registers: state, current code and latched operands.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= e_idle;
            op_r    <= '0;
            a_r     <= '0;
            b_r     <= '0;
        end else begin
            state_r <= state_n;
            op_r    <= op_n;
            a_r     <= a_n;
            b_r     <= b_n;
        end
    end

    // Next-state logic: accept a pair in idle, step through codes on each capture.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_n = state_r;
        op_n    = op_r;
        a_n     = a_r;
        b_n     = b_r;
        case (state_r)
            e_idle: begin
                if (io.v_i) begin
                    a_n     = io.a_i;
                    b_n     = io.b_i;
                    op_n    = first_code_lp;
                    state_n = e_sweep;
                end
            end
            e_sweep: begin
                if (capture) begin
                    op_n = next_code(op_mask_p, op_r);
                    if (op_r == last_code_lp) state_n = e_idle;
                end
            end
            default: state_n = e_idle;
        endcase
    end

    // Record formed from exactly what is being applied to the ALU this cycle.
    always_comb begin
        enq_rec      = '0;
        enq_rec.ctrl = op_r;
        enq_rec.a    = a_r;
        enq_rec.b    = b_r;
        enq_rec.res  = io.alu_res_i;
        enq_rec.last = (op_r == last_code_lp);
    end

    bsg_alu_operand_sequencer_result_slot #(
        .width_p ($bits(record_t))
    ) slot (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .enq_i   (capture),
        .data_i  (enq_rec),
        .yumi_i  (io.yumi_i),
        .v_o     (slot_v),
        .data_o  (slot_rec)
    );

    // ALU drive comes straight from the registers, so it holds while stalled.
    assign io.alu_control_o = op_r;
    assign io.alu_a_o       = a_r;
    assign io.alu_b_o       = b_r;

    // Handshake/status outputs are forced low for the whole reset cycle.
    assign io.ready_o   = (state_r == e_idle)  & ~reset_i;
    assign io.busy_o    = (state_r == e_sweep) & ~reset_i;
    assign io.v_o       = slot_v & ~reset_i;

    assign io.control_o = slot_rec.ctrl;
    assign io.a_o       = slot_rec.a;
    assign io.b_o       = slot_rec.b;
    assign io.res_o     = slot_rec.res;
    assign io.last_o    = slot_rec.last;

    // The consumer may only take a record that is on offer.
    a_yumi_needs_v: assert property (@(posedge clk_i) disable iff (reset_i) io.yumi_i |-> slot_v)
        else $error("bsg_alu_operand_sequencer: yumi_i asserted without v_o");

endmodule

// File: tb/tb_bsg_alu_operand_sequencer.sv
// Bench for bsg_alu_operand_sequencer: two instances (all codes enabled, and
// codes 1/3 only) each driving a behavioural ALU; records are checked against
// a queue of expected records filled at operand accept time.
module tb_bsg_alu_operand_sequencer;
    import bsg_alu_operand_sequencer_pkg::*;

    localparam int          width_lp     = 4;
    localparam logic [3:0]  mask_full_lp = 4'b1111;
    localparam logic [3:0]  mask_odd_lp  = 4'b1010;

    typedef logic [14:0] rec_t;   // {ctrl, a, b, res, last}

    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic yumi_en_full;
    logic yumi_en_odd;
    int   rec_full = 0;
    int   acc_full = 0;
    rec_t q_full[$];
    rec_t q_odd[$];

    bsg_alu_operand_sequencer_if #(.width_p(width_lp)) if_full ();
    bsg_alu_operand_sequencer_if #(.width_p(width_lp)) if_odd ();

    // Behavioural ALU: 00 add, 01 sub, 10 and, 11 or (all wrap at width).
    function automatic logic [3:0] alu_f(input logic [1:0] c, input logic [3:0] a, input logic [3:0] b);
        case (c)
            2'd0:    alu_f = a + b;
            2'd1:    alu_f = a - b;
            2'd2:    alu_f = a & b;
            default: alu_f = a | b;
        endcase
    endfunction

    function automatic int highest(input logic [3:0] mask);
        highest = 0;
        for (int k = 0; k < 4; k++) if (mask[k]) highest = k;
    endfunction

    function automatic rec_t mk_rec(input logic [1:0] c, input logic [3:0] a, input logic [3:0] b, input logic last);
        mk_rec = {c, a, b, alu_f(c, a, b), last};
    endfunction

    assign if_full.alu_res_i = alu_f(if_full.alu_control_o, if_full.alu_a_o, if_full.alu_b_o);
    assign if_odd.alu_res_i  = alu_f(if_odd.alu_control_o, if_odd.alu_a_o, if_odd.alu_b_o);
    assign if_full.yumi_i    = yumi_en_full & if_full.v_o;
    assign if_odd.yumi_i     = yumi_en_odd & if_odd.v_o;

    bsg_alu_operand_sequencer #(.width_p(width_lp), .op_mask_p(mask_full_lp)) dut_full (
        .clk_i   (clk),
        .reset_i (reset),
        .io      (if_full)
    );

    bsg_alu_operand_sequencer #(.width_p(width_lp), .op_mask_p(mask_odd_lp)) dut_odd (
        .clk_i   (clk),
        .reset_i (reset),
        .io      (if_odd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard for the all-codes instance.
    always @(negedge clk) begin
        if (!reset) begin
            if (if_full.v_i && if_full.ready_o) begin
                acc_full++;
                for (int k = 0; k < 4; k++)
                    if (mask_full_lp[k])
                        q_full.push_back(mk_rec(2'(k), if_full.a_i, if_full.b_i, k == highest(mask_full_lp)));
            end
            if (if_full.v_o && if_full.yumi_i) begin
                rec_full++;
                if (q_full.size() == 0)
                    check("full_extra_rec", 1, 0);
                else
                    check("full_rec", {if_full.control_o, if_full.a_o, if_full.b_o, if_full.res_o, if_full.last_o},
                          q_full.pop_front());
            end
        end
    end

    // Scoreboard for the odd-codes instance, plus a guard on disabled codes.
    always @(negedge clk) begin
        if (!reset) begin
            if (if_odd.v_i && if_odd.ready_o)
                for (int k = 0; k < 4; k++)
                    if (mask_odd_lp[k])
                        q_odd.push_back(mk_rec(2'(k), if_odd.a_i, if_odd.b_i, k == highest(mask_odd_lp)));
            if (if_odd.busy_o)
                check("odd_ctrl_enabled", 32'(if_odd.alu_control_o[0]), 1);
            if (if_odd.v_o && if_odd.yumi_i) begin
                if (q_odd.size() == 0)
                    check("odd_extra_rec", 1, 0);
                else
                    check("odd_rec", {if_odd.control_o, if_odd.a_o, if_odd.b_o, if_odd.res_o, if_odd.last_o},
                          q_odd.pop_front());
            end
        end
    end

    // Wait (bounded) for the pending pair to be accepted; returns just after the accept edge.
    task automatic wait_accept(input bit odd, output int c);
        bit ok = 1'b0;
        c = -1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = odd ? (if_odd.v_i && if_odd.ready_o) : (if_full.v_i && if_full.ready_o);
        end
        if (!ok) check(odd ? "accept_timeout_odd" : "accept_timeout_full", 0, 1);
        @(posedge clk);
        #1;
        c = cyc;
    endtask

    // Wait (bounded) until all expected records are delivered and the instance is idle.
    task automatic drain(input bit odd);
        bit done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (odd) done = (q_odd.size() == 0) && !if_odd.v_o && !if_odd.busy_o;
            else     done = (q_full.size() == 0) && !if_full.v_o && !if_full.busy_o;
        end
        check(odd ? "drain_odd" : "drain_full", 32'(done), 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int c1;
        int c2;
        int n0;
        bit got2;

        reset = 1'b1;
        yumi_en_full = 1'b0;
        yumi_en_odd  = 1'b0;
        if_full.v_i = 1'b0; if_full.a_i = '0; if_full.b_i = '0;
        if_odd.v_i  = 1'b0; if_odd.a_i  = '0; if_odd.b_i  = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", if_full.ready_o, 0);
        check("rst_v", if_full.v_o, 0);
        check("rst_busy", if_full.busy_o, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("idle_ready", if_full.ready_o, 1);
        check("idle_v", if_full.v_o, 0);
        check("idle_alu_a", if_full.alu_a_o, 0);
        @(posedge clk); #1;

        // 1: full sweep with the consumer always ready.
        yumi_en_full = 1'b1;
        if_full.v_i = 1'b1; if_full.a_i = 4'd1; if_full.b_i = 4'd3;
        wait_accept(0, c1);
        if_full.v_i = 1'b0;
        @(negedge clk);
        check("t1_lat_v", if_full.v_o, 0);
        check("t1_busy", if_full.busy_o, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t1_v", if_full.v_o, 1);
            check("t1_ctrl", if_full.control_o, i);
            check("t1_a", if_full.a_o, 1);
            check("t1_b", if_full.b_o, 3);
            check("t1_last", if_full.last_o, (i == 3) ? 1 : 0);
            check("t1_ready", if_full.ready_o, (i == 3) ? 1 : 0);
        end
        @(negedge clk);
        check("t1_v_clear", if_full.v_o, 0);
        drain(0);

        // 2: sparse mask, only codes 1 and 3.
        yumi_en_odd = 1'b1;
        if_odd.v_i = 1'b1; if_odd.a_i = 4'd5; if_odd.b_i = 4'd2;
        wait_accept(1, c1);
        if_odd.v_i = 1'b0;
        @(negedge clk);
        check("t2_first_alu_ctrl", if_odd.alu_control_o, 1);
        check("t2_lat_v", if_odd.v_o, 0);
        @(negedge clk);
        check("t2_r0_v", if_odd.v_o, 1);
        check("t2_r0_ctrl", if_odd.control_o, 1);
        check("t2_r0_last", if_odd.last_o, 0);
        @(negedge clk);
        check("t2_r1_v", if_odd.v_o, 1);
        check("t2_r1_ctrl", if_odd.control_o, 3);
        check("t2_r1_last", if_odd.last_o, 1);
        check("t2_ready", if_odd.ready_o, 1);
        @(negedge clk);
        check("t2_v_clear", if_odd.v_o, 0);
        drain(1);

        // 3: consumer stalls five cycles after the first capture.
        yumi_en_full = 1'b0;
        if_full.v_i = 1'b1; if_full.a_i = 4'd6; if_full.b_i = 4'd2;
        wait_accept(0, c1);
        if_full.v_i = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_hold_v", if_full.v_o, 1);
            check("t3_hold_ctrl", if_full.control_o, 0);
            check("t3_hold_res", if_full.res_o, 4'd8);
            check("t3_alu_ctrl", if_full.alu_control_o, 1);
        end
        @(posedge clk); #1;
        yumi_en_full = 1'b1;
        drain(0);

        // 4: back-to-back pairs with v_i held high; all-ones wraps.
        n0 = rec_full;
        if_full.v_i = 1'b1; if_full.a_i = 4'd1; if_full.b_i = 4'd3;
        wait_accept(0, c1);
        if_full.a_i = 4'hf; if_full.b_i = 4'hf;
        wait_accept(0, c2);
        if_full.v_i = 1'b0;
        check("t4_gap", c2 - c1, 5);
        drain(0);
        check("t4_count", rec_full - n0, 8);

        // 5: reset in the middle of a sweep.
        n0 = rec_full;
        if_full.v_i = 1'b1; if_full.a_i = 4'd9; if_full.b_i = 4'd4;
        wait_accept(0, c1);
        if_full.v_i = 1'b0;
        got2 = 1'b0;
        for (int i = 0; i < 20 && !got2; i++) begin
            @(posedge clk); #1;
            got2 = (rec_full >= n0 + 2);
        end
        check("t5_two_recs", 32'(got2), 1);
        reset = 1'b1;
        q_full.delete();
        q_odd.delete();
        @(negedge clk);
        check("t5_rst_v", if_full.v_o, 0);
        check("t5_rst_busy", if_full.busy_o, 0);
        check("t5_rst_ready", if_full.ready_o, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("t5_post_ready", if_full.ready_o, 1);
        check("t5_post_v", if_full.v_o, 0);
        check("t5_post_busy", if_full.busy_o, 0);
        @(posedge clk); #1;
        if_full.v_i = 1'b1; if_full.a_i = 4'd7; if_full.b_i = 4'd7;
        wait_accept(0, c1);
        if_full.v_i = 1'b0;
        @(negedge clk);
        check("t5_restart_alu_ctrl", if_full.alu_control_o, 0);
        @(negedge clk);
        check("t5_restart_v", if_full.v_o, 1);
        check("t5_restart_ctrl", if_full.control_o, 0);
        drain(0);

        // 6: v_i held while busy with operands changing every cycle.
        if_full.v_i = 1'b1; if_full.a_i = 4'd2; if_full.b_i = 4'd5;
        wait_accept(0, c1);
        n0 = acc_full;
        for (int i = 0; i < 12; i++) begin
            if_full.a_i = 4'($urandom);
            if_full.b_i = 4'($urandom);
            @(posedge clk); #1;
        end
        if_full.v_i = 1'b0;
        check("t6_accepts", acc_full - n0, 2);
        drain(0);

        check("sb_full_empty", q_full.size(), 0);
        check("sb_odd_empty", q_odd.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
